// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a main output register backed by one skid entry.
// Define DECODE_RV32M_EN to accept the RV32M multiply/divide encodings (ALU opcode, func7 0000001).
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_rd_we,
    output logic            out_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
`ifdef DECODE_RV32M_EN
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_SHAMT,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            rs1_used;
        logic            rs2_used;
        logic            rd_we;
        logic            illegal;
    } entry_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        use_rs1;
    logic        use_rs2;
    logic        writes_rd;
    logic        legal;
    imm_fmt_e    fmt;
    logic [31:0] imm32;
    entry_t      dec;

    // NOTE: every signal written in an always_comb gets a default at the top of the block;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        opc       = in_instr[6:0];
        f3        = in_instr[14:12];
        f7        = in_instr[31:25];
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        legal     = 1'b1;
        fmt       = FMT_NONE;

        case (opc)
            OP_LUI, OP_AUIPC: begin
                writes_rd = 1'b1;
                fmt       = FMT_U;
            end
            OP_JAL: begin
                writes_rd = 1'b1;
                fmt       = FMT_J;
            end
            OP_JALR: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                fmt       = FMT_I;
                legal     = (f3 == 3'b000);
            end
            OP_LOAD: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                fmt       = FMT_I;
            end
            OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                fmt     = FMT_S;
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                fmt     = FMT_B;
            end
            OP_ALUI: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                fmt       = FMT_I;
                if (f3 == 3'b001) begin
                    fmt   = FMT_SHAMT;
                    legal = (f7 == F7_BASE);
                end else if (f3 == 3'b101) begin
                    fmt   = FMT_SHAMT;
                    legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                end
            end
            OP_ALU: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
                case (f7)
                    F7_BASE:   legal = 1'b1;
                    F7_ALT:    legal = (f3 == 3'b000) || (f3 == 3'b101);
`ifdef DECODE_RV32M_EN
                    F7_MULDIV: legal = 1'b1;
`endif
                    default:   legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        case (fmt)
            FMT_I:     imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_SHAMT: imm32 = {27'd0, in_instr[24:20]};
            FMT_S:     imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:     imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:     imm32 = {in_instr[31:12], 12'd0};
            FMT_J:     imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            default:   imm32 = 32'd0;
        endcase

        // Illegal entries still flow downstream, but with no operands, writeback or immediate.
        dec         = '0;
        dec.pc      = in_pc;
        dec.opcode  = opc;
        dec.func3   = f3;
        dec.func7   = f7;
        dec.illegal = !legal;
        if (legal) begin
            dec.rs1_used = use_rs1;
            dec.rs2_used = use_rs2;
            dec.rd_we    = writes_rd && (in_instr[11:7] != 5'd0);
            dec.rs1      = use_rs1 ? in_instr[19:15] : 5'd0;
            dec.rs2      = use_rs2 ? in_instr[24:20] : 5'd0;
            dec.rd       = dec.rd_we ? in_instr[11:7] : 5'd0;
            dec.imm      = sext32(imm32);
        end
    end

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;
    logic   drain;

    assign in_ready = !skid_valid_q;

    // An accept only happens with the skid empty, so a drain either promotes the skid
    // entry or frees main for the incoming instruction -- never both.
    always_comb begin
        accept       = in_valid && in_ready;
        drain        = main_valid_q && out_ready;
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (drain) begin
                main_valid_d = skid_valid_q;
                skid_valid_d = 1'b0;
                if (skid_valid_q) begin
                    main_d = skid_q;
                end
            end
            if (accept) begin
                if (!main_valid_d) begin
                    main_d       = dec;
                    main_valid_d = 1'b1;
                end else begin
                    skid_d       = dec;
                    skid_valid_d = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its _d input regardless of process ordering.
    // NOTE: the data registers are reset as well as the valid bits, because every
    // output must read zero straight out of reset, not just out_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid    = main_valid_q;
    assign out_pc       = main_q.pc;
    assign out_opcode   = main_q.opcode;
    assign out_func3    = main_q.func3;
    assign out_func7    = main_q.func7;
    assign out_rs1      = main_q.rs1;
    assign out_rs2      = main_q.rs2;
    assign out_rd       = main_q.rd;
    assign out_imm      = main_q.imm;
    assign out_rs1_used = main_q.rs1_used;
    assign out_rs2_used = main_q.rs2_used;
    assign out_rd_we    = main_q.rd_we;
    assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a decode vector table streamed through a scoreboard, plus
// hand-written stall, flush and mid-stream reset sequences.
module tb_decode_stage;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_func3;
    logic [6:0]      out_func7;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_rs1_used;
    logic            out_rs2_used;
    logic            out_rd_we;
    logic            out_illegal;

    decode_stage #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_opcode   (out_opcode),
        .out_func3    (out_func3),
        .out_func7    (out_func7),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_imm      (out_imm),
        .out_rs1_used (out_rs1_used),
        .out_rs2_used (out_rs2_used),
        .out_rd_we    (out_rd_we),
        .out_illegal  (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        rs1_used;
        logic        rs2_used;
        logic        rd_we;
        logic        illegal;
    } out_t;

    // flags = {rs1_used, rs2_used, rd_we, illegal}
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  flags;
    } vec_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    sb_t  cur;
    logic bp_en;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input string name, input logic [31:0] instr,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [4:0] rd, input logic [31:0] imm,
                                    input logic [3:0] flags);
        vec_t v;
        v.name  = name;
        v.instr = instr;
        v.rs1   = rs1;
        v.rs2   = rs2;
        v.rd    = rd;
        v.imm   = imm;
        v.flags = flags;
        vecs.push_back(v);
    endfunction

    function automatic out_t make_exp(input vec_t v, input logic [31:0] pc);
        out_t e;
        e.pc     = pc;
        e.opcode = v.instr[6:0];
        e.func3  = v.instr[14:12];
        e.func7  = v.instr[31:25];
        e.rs1    = v.rs1;
        e.rs2    = v.rs2;
        e.rd     = v.rd;
        e.imm    = v.imm;
        {e.rs1_used, e.rs2_used, e.rd_we, e.illegal} = v.flags;
        return e;
    endfunction

    function automatic out_t actual_out();
        out_t a;
        a.pc       = out_pc;
        a.opcode   = out_opcode;
        a.func3    = out_func3;
        a.func7    = out_func7;
        a.rs1      = out_rs1;
        a.rs2      = out_rs2;
        a.rd       = out_rd;
        a.imm      = out_imm;
        a.rs1_used = out_rs1_used;
        a.rs2_used = out_rs2_used;
        a.rd_we    = out_rd_we;
        a.illegal  = out_illegal;
        return a;
    endfunction

    // Scoreboard: observe handshakes mid-cycle, ahead of the edge that acts on them.
    always @(negedge clk) begin
        if (!reset_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output: got pc=%h opcode=%h, expected no output",
                             out_pc, out_opcode);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check(e.name, 128'(actual_out()), 128'(e.exp));
                end
            end
            if (in_valid && in_ready) sb.push_back(cur);
        end
    end

    task automatic wait_accept(output int waited);
        logic acc;
        acc    = 1'b0;
        waited = 0;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected acceptance");
        end
    endtask

    task automatic present(input int idx, input logic [31:0] pc);
        in_instr = vecs[idx].instr;
        in_pc    = pc;
        cur.name = vecs[idx].name;
        cur.exp  = make_exp(vecs[idx], pc);
        in_valid = 1'b1;
    endtask

    task automatic send(input int idx, input logic [31:0] pc, output int waited);
        present(idx, pc);
        wait_accept(waited);
    endtask

    task automatic drain();
        logic done;
        done      = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(posedge clk);
            #2;
            done = (sb.size() == 0) && !out_valid;
        end
        check("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        int w;
        int cycles;

        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        bp_en     = 1'b0;

        add_vec("addi_neg",   32'hFFF08293, 5'd1, 5'd0, 5'd5,  32'hFFFFFFFF, 4'b1010);
        add_vec("beq_back",   32'hFE000EE3, 5'd0, 5'd0, 5'd0,  32'hFFFFFFFC, 4'b1100);
        add_vec("bne_fwd",    32'h00209863, 5'd1, 5'd2, 5'd0,  32'h00000010, 4'b1100);
        add_vec("sw",         32'h00512423, 5'd2, 5'd5, 5'd0,  32'h00000008, 4'b1100);
        add_vec("lui",        32'h12345537, 5'd0, 5'd0, 5'd10, 32'h12345000, 4'b0010);
        add_vec("auipc",      32'h80000197, 5'd0, 5'd0, 5'd3,  32'h80000000, 4'b0010);
        add_vec("jal_back",   32'hFF9FF0EF, 5'd0, 5'd0, 5'd1,  32'hFFFFFFF8, 4'b0010);
        add_vec("jalr_x0",    32'h00008067, 5'd1, 5'd0, 5'd0,  32'h00000000, 4'b1000);
        add_vec("jalr_f3",    32'h00009067, 5'd0, 5'd0, 5'd0,  32'h00000000, 4'b0001);
        add_vec("lw_neg",     32'hFFC12303, 5'd2, 5'd0, 5'd6,  32'hFFFFFFFC, 4'b1010);
        add_vec("srai_31",    32'h41F45393, 5'd8, 5'd0, 5'd7,  32'h0000001F, 4'b1010);
        add_vec("slli_1",     32'h00141093, 5'd8, 5'd0, 5'd1,  32'h00000001, 4'b1010);
        add_vec("slli_f7",    32'h40141093, 5'd0, 5'd0, 5'd0,  32'h00000000, 4'b0001);
        add_vec("srli_f7",    32'h02345393, 5'd0, 5'd0, 5'd0,  32'h00000000, 4'b0001);
        add_vec("sub",        32'h402081B3, 5'd1, 5'd2, 5'd3,  32'h00000000, 4'b1110);
        add_vec("alu_alt_f3", 32'h402091B3, 5'd0, 5'd0, 5'd0,  32'h00000000, 4'b0001);
`ifdef DECODE_RV32M_EN
        add_vec("mul_x0",     32'h02208033, 5'd1, 5'd2, 5'd0,  32'h00000000, 4'b1100);
        add_vec("mul_x3",     32'h022081B3, 5'd1, 5'd2, 5'd3,  32'h00000000, 4'b1110);
`else
        add_vec("mul_x0",     32'h02208033, 5'd0, 5'd0, 5'd0,  32'h00000000, 4'b0001);
        add_vec("mul_x3",     32'h022081B3, 5'd0, 5'd0, 5'd0,  32'h00000000, 4'b0001);
`endif
        add_vec("opcode_7f",  32'h0000007F, 5'd0, 5'd0, 5'd0,  32'h00000000, 4'b0001);

        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_in_ready",  128'(in_ready),  128'(1));
        check("reset_outputs",   128'(actual_out()), 128'(0));
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-rate stream: every vector must be taken on its first cycle.
        out_ready = 1'b1;
        cycles    = 0;
        foreach (vecs[i]) begin
            send(i, 32'h1000 + 32'(4 * i), w);
            cycles += w;
        end
        check("stream_throughput", 128'(cycles), 128'(vecs.size()));
        drain();

        // Same table under random back-pressure.
        bp_en = 1'b1;
        foreach (vecs[i]) send(i, 32'h2000 + 32'(4 * i), w);
        bp_en = 1'b0;
        drain();

        // Stall: A to main, B to skid, C held off until the release.
        out_ready = 1'b0;
        send(0, 32'h3000, w);
        send(3, 32'h3004, w);
        present(4, 32'h3008);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready",  128'(in_ready),  128'(0));
            check("stall_out_valid", 128'(out_valid), 128'(1));
            check("stall_hold_pc",   128'(out_pc),    128'(32'h3000));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept(w);
        drain();

        // Flush with both entries full and a new instruction offered.
        out_ready = 1'b0;
        send(1, 32'h4000, w);
        send(2, 32'h4004, w);
        present(5, 32'h4008);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_full_out_valid", 128'(out_valid), 128'(0));
        check("flush_full_in_ready",  128'(in_ready),  128'(1));
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Flush with only main full: the simultaneous accept must vanish.
        out_ready = 1'b0;
        send(6, 32'h5000, w);
        present(7, 32'h5004);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_main_out_valid", 128'(out_valid), 128'(0));
        check("flush_main_in_ready",  128'(in_ready),  128'(1));
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(9, 32'h5008, w);
        drain();

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        send(10, 32'h6000, w);
        send(11, 32'h6004, w);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 128'(out_valid),    128'(0));
        check("rst_mid_in_ready",  128'(in_ready),     128'(1));
        check("rst_mid_outputs",   128'(actual_out()), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(14, 32'h7000, w);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
